// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit.
// A Moore FSM steps each instruction through fetch, decode and its execute,
// memory and writeback states and drives the datapath enables and selects.
// The current state is exported on `state` so checkers can bind to it.
// There are no valid/ready handshakes on this block. Instruction fields are
// plain level inputs that are looked at only in DECODE, MEMADR and RTYPEEX.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       pcwrite;
    logic       branch;

    assign state = state_q;

    // State register. Reset forces FETCH asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused codes 12-15 fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Per-state outputs. Everything is held at 0 while reset is high.
    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                end
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    iord = 1'b1;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100000: alucontrol = 3'b000;
                        6'b100010: alucontrol = 3'b001;
                        6'b100100: alucontrol = 3'b010;
                        6'b100101: alucontrol = 3'b011;
                        6'b101010: alucontrol = 3'b100;
                        default:   alucontrol = 3'b111;
                    endcase
                end
                RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca    = 1'b1;
                    branch     = 1'b1;
                    pcsrc      = 2'b01;
                    alucontrol = 3'b001;
                end
                ADDIWB: begin
                    regwrite = 1'b1;
                end
                JEX: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
                default: begin
                end
            endcase
        end
    end

    // The PC is written on fetch or jump, and on a branch only when the ALU
    // reports equality.
    assign pcen = pcwrite | (branch & zero);

endmodule
